// File: rtl/note_player.sv
// Note sequencer: turns (note, beats) commands into a sine-reader phase step
// and sample requests, and gates returned samples toward the codec.

module frequency_rom (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [19:0] dout
);
    // Phase steps for equal temperament, note 49 = A440, 48 kHz, 2^20 phase
    always_ff @(posedge clk) begin
        case (addr)
            6'd1:  dout <= 20'd601;
            6'd2:  dout <= 20'd636;
            6'd3:  dout <= 20'd674;
            6'd4:  dout <= 20'd714;
            6'd5:  dout <= 20'd757;
            6'd6:  dout <= 20'd802;
            6'd7:  dout <= 20'd850;
            6'd8:  dout <= 20'd900;
            6'd9:  dout <= 20'd954;
            6'd10: dout <= 20'd1010;
            6'd11: dout <= 20'd1070;
            6'd12: dout <= 20'd1134;
            6'd13: dout <= 20'd1201;
            6'd14: dout <= 20'd1273;
            6'd15: dout <= 20'd1349;
            6'd16: dout <= 20'd1429;
            6'd17: dout <= 20'd1514;
            6'd18: dout <= 20'd1604;
            6'd19: dout <= 20'd1699;
            6'd20: dout <= 20'd1800;
            6'd21: dout <= 20'd1907;
            6'd22: dout <= 20'd2021;
            6'd23: dout <= 20'd2141;
            6'd24: dout <= 20'd2268;
            6'd25: dout <= 20'd2403;
            6'd26: dout <= 20'd2546;
            6'd27: dout <= 20'd2697;
            6'd28: dout <= 20'd2858;
            6'd29: dout <= 20'd3028;
            6'd30: dout <= 20'd3208;
            6'd31: dout <= 20'd3398;
            6'd32: dout <= 20'd3600;
            6'd33: dout <= 20'd3815;
            6'd34: dout <= 20'd4041;
            6'd35: dout <= 20'd4282;
            6'd36: dout <= 20'd4536;
            6'd37: dout <= 20'd4806;
            6'd38: dout <= 20'd5092;
            6'd39: dout <= 20'd5395;
            6'd40: dout <= 20'd5715;
            6'd41: dout <= 20'd6055;
            6'd42: dout <= 20'd6415;
            6'd43: dout <= 20'd6797;
            6'd44: dout <= 20'd7201;
            6'd45: dout <= 20'd7629;
            6'd46: dout <= 20'd8083;
            6'd47: dout <= 20'd8563;
            6'd48: dout <= 20'd9072;
            6'd49: dout <= 20'd9612;
            6'd50: dout <= 20'd10184;
            6'd51: dout <= 20'd10789;
            6'd52: dout <= 20'd11431;
            6'd53: dout <= 20'd12110;
            6'd54: dout <= 20'd12830;
            6'd55: dout <= 20'd13593;
            6'd56: dout <= 20'd14402;
            6'd57: dout <= 20'd15258;
            6'd58: dout <= 20'd16165;
            6'd59: dout <= 20'd17127;
            6'd60: dout <= 20'd18145;
            6'd61: dout <= 20'd19224;
            6'd62: dout <= 20'd20367;
            6'd63: dout <= 20'd21578;
            default: dout <= 20'd0;
        endcase
    end
endmodule

module note_player #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int STEP_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_enable,
    input  logic [NOTE_W-1:0] note_to_load,
    input  logic [DUR_W-1:0]  duration_to_load,
    input  logic              load_new_note,
    input  logic              beat,
    input  logic              generate_next_sample,
    output logic              done_with_note,
    output logic [STEP_W-1:0] step_size,
    output logic              generate_next,
    input  logic [15:0]       sample_in,
    input  logic              sample_ready_in,
    output logic [15:0]       sample_out,
    output logic              new_sample_ready
);
    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t            state;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
    logic [DUR_W-1:0]  count;
    logic [NOTE_W-1:0] rom_addr;
    logic [STEP_W-1:0] rom_dout;

    // Address the ROM with the incoming note on a load so FETCH sees its data
    assign rom_addr = load_new_note ? note_to_load : note;

    frequency_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    assign generate_next = generate_next_sample && play_enable && (state == PLAY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            note             <= '0;
            dur              <= '0;
            count            <= '0;
            step_size        <= '0;
            done_with_note   <= 1'b0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
        end else begin
            done_with_note   <= 1'b0;
            new_sample_ready <= sample_ready_in;
            if (sample_ready_in)
                sample_out <= (state == PLAY && note != '0) ? sample_in : '0;

            if (load_new_note) begin
                note  <= note_to_load;
                dur   <= duration_to_load;
                state <= FETCH;
            end else begin
                case (state)
                    IDLE: step_size <= '0;
                    FETCH: begin
                        if (dur == '0) begin
                            done_with_note <= 1'b1;
                            step_size      <= '0;
                            state          <= IDLE;
                        end else begin
                            step_size <= (note == '0) ? '0 : rom_dout;
                            count     <= dur;
                            state     <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (beat && play_enable) begin
                            count <= count - DUR_W'(1);
                            if (count == DUR_W'(1)) begin
                                done_with_note <= 1'b1;
                                step_size      <= '0;
                                state          <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed scenarios plus random traffic against a
// note-level reference model with a two-cycle sine-reader stand-in.

module tb_note_player;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play_enable = 1'b0;
    logic [5:0]  note_to_load = '0;
    logic [5:0]  duration_to_load = '0;
    logic        load_new_note = 1'b0;
    logic        beat = 1'b0;
    logic        generate_next_sample = 1'b0;
    logic        done_with_note;
    logic [19:0] step_size;
    logic        generate_next;
    logic [15:0] sample_in;
    logic        sample_ready_in;
    logic [15:0] sample_out;
    logic        new_sample_ready;

    logic [15:0] sine_val = '0;
    logic [15:0] man_val = '0;
    logic        man_sr = 1'b0;
    logic        p0 = 1'b0;
    logic        p1 = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_active = 0;
    bit          m_fetch = 0;
    int          m_rem = 0;
    int          m_dur = 0;
    int          m_note = 0;
    int          e_step = 0;
    bit          e_done = 0;
    bit          e_nsr = 0;
    logic [15:0] e_sout = '0;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .load_new_note        (load_new_note),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .done_with_note       (done_with_note),
        .step_size            (step_size),
        .generate_next        (generate_next),
        .sample_in            (sample_in),
        .sample_ready_in      (sample_ready_in),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready)
    );

    always #5 clk = ~clk;

    // sine reader: answers a request two cycles later
    always @(posedge clk) begin
        p0 <= generate_next;
        p1 <= p0;
    end
    assign sample_ready_in = p1 | man_sr;
    assign sample_in       = p1 ? sine_val : man_val;

    function automatic int freq(input int n);
        real f;
        if (n == 0) return 0;
        f = 440.0 * $pow(2.0, (n - 49) / 12.0) * 1048576.0 / 48000.0;
        return $rtoi(f + 0.5);
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ok;
        int d;
        bit exp_gen;
        exp_gen = generate_next_sample && play_enable && m_active && !m_fetch;
        chk("done_with_note", 20'(done_with_note), 20'(e_done));
        chk("generate_next", 20'(generate_next), 20'(exp_gen));
        chk("new_sample_ready", 20'(new_sample_ready), 20'(e_nsr));
        chk("sample_out", 20'(sample_out), 20'(e_sout));
        // table entries are rounded; allow one LSB against the real-valued model
        d  = int'(step_size) - e_step;
        ok = !$isunknown(step_size) &&
             ((e_step == 0) ? (step_size == '0) : (d >= -1 && d <= 1));
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL step_size: observed %0d expected %0d", step_size, e_step);
        end
    endtask

    task automatic advance_model();
        bit playing;
        playing = m_active && !m_fetch;
        if (reset) begin
            e_done = 0; e_nsr = 0; e_sout = '0; e_step = 0;
            m_active = 0; m_fetch = 0; m_rem = 0; m_note = 0; m_dur = 0;
        end else begin
            e_done = 0;
            e_nsr  = sample_ready_in;
            if (sample_ready_in)
                e_sout = (playing && m_note != 0) ? sample_in : 16'h0;
            if (load_new_note) begin
                m_note = note_to_load;
                m_dur = duration_to_load;
                m_active = 1;
                m_fetch = 1;
            end else if (m_fetch) begin
                m_fetch = 0;
                if (m_dur == 0) begin
                    m_active = 0;
                    e_done = 1;
                    e_step = 0;
                end else begin
                    m_rem = m_dur;
                    e_step = freq(m_note);
                end
            end else if (playing && beat && play_enable) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 0;
                    e_done = 1;
                    e_step = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        advance_model();
        @(posedge clk);
        #1;
        load_new_note = 1'b0;
        beat = 1'b0;
        man_sr = 1'b0;
        generate_next_sample = 1'b0;
    endtask

    task automatic load(input int n, input int d);
        note_to_load = 6'(n);
        duration_to_load = 6'(d);
        load_new_note = 1'b1;
        step();
    endtask

    task automatic run(input int n, input int beat_per, input int gen_per);
        for (int i = 0; i < n; i++) begin
            beat = (beat_per > 0) && (i % beat_per == beat_per - 1);
            if (gen_per > 0 && i % gen_per == 0) begin
                generate_next_sample = 1'b1;
                sine_val = 16'($urandom);
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        reset = 1'b0;
        play_enable = 1'b1;

        // note 49 for three beats
        load(49, 3);
        run(60, 16, 3);

        // rest: returned samples must be silenced
        load(0, 2);
        for (int i = 0; i < 40; i++) begin
            beat = (i % 16 == 15);
            man_sr = (i % 5 == 2);
            man_val = 16'h1234;
            step();
        end

        // pause across three beats
        load(20, 4);
        run(10, 8, 2);
        play_enable = 1'b0;
        run(24, 8, 2);
        play_enable = 1'b1;
        run(40, 8, 2);

        // restart with a load that coincides with a beat
        load(45, 4);
        run(17, 8, 4);
        beat = 1'b1;
        load(30, 5);
        run(60, 8, 4);

        // zero-length note
        load(10, 0);
        run(10, 0, 1);

        // known sample through the sine reader, then reset mid-note
        load(33, 6);
        run(3, 0, 0);
        sine_val = 16'hF00D;
        generate_next_sample = 1'b1;
        step();
        run(5, 0, 0);
        run(6, 0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(10, 4, 2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 500 == 0);
            play_enable = ($urandom % 8 != 0);
            beat = ($urandom % 6 == 0);
            generate_next_sample = ($urandom % 3 == 0);
            sine_val = 16'($urandom);
            man_sr = ($urandom % 29 == 0);
            man_val = 16'($urandom);
            if ($urandom % 40 == 0) begin
                note_to_load = 6'($urandom);
                duration_to_load = 6'($urandom % 8);
                load_new_note = 1'b1;
            end
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
